// File: rtl/vending_machine_param_if.sv
// vending_machine_param_if: coin/cancel inputs and vend/refund outputs of the vending machine
// Signals: pi_money_half, pi_money_one, pi_cancel (customer side, driven by master);
//   po_beverage, po_money[CREDIT_W], po_refund, po_sold_cnt[SOLD_W] (machine side, driven by slave).
interface vending_machine_param_if #(
  parameter int CREDIT_W = 4,
  parameter int SOLD_W = 8
);
  logic pi_money_half;
  logic pi_money_one;
  logic pi_cancel;
  logic po_beverage;
  logic po_refund;
  logic [CREDIT_W-1:0] po_money;
  logic [SOLD_W-1:0] po_sold_cnt;
  modport master(
    output pi_money_half, pi_money_one, pi_cancel,
    input po_beverage, po_refund, po_money, po_sold_cnt
  );
  modport slave(
    input pi_money_half, pi_money_one, pi_cancel,
    output po_beverage, po_refund, po_money, po_sold_cnt
  );
endinterface

// File: rtl/vending_machine_param.sv
// vending_machine_param: half-unit credit vending FSM with change, sold counter and optional cancel refund
// Ports: sys_clk; sys_rst_n (async, active-low); bus (slave): pi_money_half, pi_money_one, pi_cancel in,
//   po_beverage, po_money, po_refund, po_sold_cnt out. Define VM_CANCEL_EN to enable cancel/refund.
module vending_machine_param #(
  parameter int PRICE = 3,
  parameter int CREDIT_W = 4,
  parameter int SOLD_W = 8
) (
  input logic sys_clk,
  input logic sys_rst_n,
  vending_machine_param_if.slave bus
);
`ifdef VM_CANCEL_EN
  typedef enum logic [3:0] {IDLE = 4'b0001, COLLECT = 4'b0010, VEND = 4'b0100, REFUND = 4'b1000} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'b001, COLLECT = 3'b010, VEND = 3'b100} state_t;
`endif
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n, coin, sum, money, money_n;
  logic [SOLD_W-1:0] sold, sold_n;
  logic beverage, refund, legal, cancel, vend;
  // {one, half} is exactly one*2 + half; credit is only nonzero in COLLECT
  assign coin = CREDIT_W'({bus.pi_money_one, bus.pi_money_half});
  assign sum = credit + coin;
  always_comb begin
`ifdef VM_CANCEL_EN
    legal = state inside {IDLE, COLLECT, VEND, REFUND};
    cancel = legal && bus.pi_cancel && sum != '0;
`else
    legal = state inside {IDLE, COLLECT, VEND};
    cancel = 1'b0;
`endif
    vend = legal && !cancel && sum >= CREDIT_W'(PRICE);
`ifdef VM_CANCEL_EN
    state_n = !legal ? IDLE : cancel ? REFUND : vend ? VEND : sum != '0 ? COLLECT : IDLE;
`else
    state_n = !legal ? IDLE : vend ? VEND : sum != '0 ? COLLECT : IDLE;
`endif
    credit_n = (legal && !cancel && !vend) ? sum : '0;
    money_n = vend ? sum - CREDIT_W'(PRICE) : cancel ? sum : '0;
    sold_n = vend ? sold + SOLD_W'(1) : sold;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      credit <= '0;
      money <= '0;
      sold <= '0;
      beverage <= 1'b0;
      refund <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      money <= money_n;
      sold <= sold_n;
      beverage <= vend;
      refund <= cancel;
    end
  end
  assign bus.po_beverage = beverage;
  assign bus.po_refund = refund;
  assign bus.po_money = money;
  assign bus.po_sold_cnt = sold;
endmodule
